// File: rtl/peak_detect_mc_if.sv
// Streaming bus of peak_detect_mc: per-bin sample sink and per-range peak-record source.
// sink_thresh exists only when PEAK_DETECT_MC_THRESH_EN is defined.
interface peak_detect_mc_if #(
  parameter int WIDTH  = 16,
  parameter int NCH    = 2,
  parameter int BWIDTH = 7
);
  logic                   sink_valid;
  logic                   sink_ready;
  logic                   sink_sop;
  logic                   sink_eop;
  logic [NCH*WIDTH-1:0]   sink_mag;
  logic [NCH*16-1:0]      sink_phase;
`ifdef PEAK_DETECT_MC_THRESH_EN
  logic [WIDTH-1:0]       sink_thresh;
`endif
  logic                   source_valid;
  logic                   source_ready;
  logic                   source_sop;
  logic                   source_eop;
  logic                   source_found;
  logic [BWIDTH-1:0]      source_bin;
  logic [3*WIDTH-1:0]     source_mag;
  logic [NCH*48-1:0]      source_phase;

  modport slave (
    input  sink_valid, sink_sop, sink_eop, sink_mag, sink_phase,
`ifdef PEAK_DETECT_MC_THRESH_EN
    input  sink_thresh,
`endif
    output sink_ready,
    output source_valid, source_sop, source_eop, source_found,
    output source_bin, source_mag, source_phase,
    input  source_ready
  );

  modport master (
    output sink_valid, sink_sop, sink_eop, sink_mag, sink_phase,
`ifdef PEAK_DETECT_MC_THRESH_EN
    output sink_thresh,
`endif
    input  sink_ready,
    input  source_valid, source_sop, source_eop, source_found,
    input  source_bin, source_mag, source_phase,
    output source_ready
  );
endinterface

// File: rtl/peak_detect_mc.sv
// Multi-channel spectral peak detector: keeps the strongest REFCH bin per range, then emits one
// record per range. Optional threshold qualification of source_found: PEAK_DETECT_MC_THRESH_EN.
module peak_detect_mc #(
  parameter int WIDTH              = 16,
  parameter int NCH                = 2,
  parameter int REFCH              = 0,
  parameter int NPEAKS             = 2,
  parameter int PEAKSEP [0:NPEAKS] = '{4, 64, 128}
) (
  input  logic            clk,
  input  logic            reset,
  peak_detect_mc_if.slave bus
);
  localparam int BWIDTH = $clog2(PEAKSEP[NPEAKS]);
  localparam int CWIDTH = BWIDTH + 1;
  localparam int IWIDTH = (NPEAKS > 1) ? $clog2(NPEAKS) : 1;
  localparam int LIMIT  = PEAKSEP[NPEAKS];

  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_e;
  typedef logic [NCH*WIDTH-1:0] mag_vec_t;
  typedef logic [NCH*16-1:0]    ph_vec_t;
  typedef struct packed {
    logic               valid;
    logic [BWIDTH-1:0]  bin;
    logic [3*WIDTH-1:0] mag;
    logic [NCH*48-1:0]  phase;
  } rec_t;

  state_e            state_q, state_d;
  logic [CWIDTH-1:0] cnt_q, cnt_d;
  logic [IWIDTH-1:0] idx_q, idx_d;
  logic              drop_q, drop_d;
  mag_vec_t          win_mag_q [2];
  mag_vec_t          win_mag_d [2];
  ph_vec_t           win_ph_q  [2];
  ph_vec_t           win_ph_d  [2];
  rec_t              rec_q [NPEAKS];
  rec_t              rec_d [NPEAKS];
`ifdef PEAK_DETECT_MC_THRESH_EN
  logic [WIDTH-1:0]  thresh_q, thresh_d;
`endif

  logic accept, start, eval_a, eval_b;
  rec_t cand_a, cand_b, cur_rec;

  function automatic rec_t make_rec(input logic [CWIDTH-1:0] k,
                                    input mag_vec_t pm, input mag_vec_t cm, input mag_vec_t nm,
                                    input ph_vec_t pp, input ph_vec_t cp, input ph_vec_t np);
    rec_t r;
    r.valid = 1'b1;
    r.bin   = k[BWIDTH-1:0];
    r.mag   = {nm[REFCH*WIDTH +: WIDTH], cm[REFCH*WIDTH +: WIDTH], pm[REFCH*WIDTH +: WIDTH]};
    for (int c = 0; c < NCH; c++) begin
      r.phase[c*48 +: 48] = {np[c*16 +: 16], cp[c*16 +: 16], pp[c*16 +: 16]};
    end
    return r;
  endfunction

  // Candidate bins are always below LIMIT, so the truncated bin field still identifies the range.
  function automatic rec_t offer(input rec_t cur, input rec_t cand, input int i);
    if (int'(cand.bin) >= PEAKSEP[i] && int'(cand.bin) < PEAKSEP[i+1] &&
        cand.mag[WIDTH +: WIDTH] > cur.mag[WIDTH +: WIDTH]) begin
      return cand;
    end
    return cur;
  endfunction

  assign bus.sink_ready = (state_q != EMIT) || drop_q;
  assign accept         = bus.sink_valid && bus.sink_ready;
  assign start          = accept && bus.sink_sop && (state_q != EMIT);

  // Window: [0] holds bin n-1, [1] holds bin n-2, where n is the bin being accepted.
  assign cand_a = make_rec(cnt_q - CWIDTH'(1), win_mag_q[1], win_mag_q[0], bus.sink_mag,
                           win_ph_q[1], win_ph_q[0], bus.sink_phase);
  assign cand_b = make_rec(start ? '0 : cnt_q, start ? '0 : win_mag_q[0], bus.sink_mag, '0,
                           start ? '0 : win_ph_q[0], bus.sink_phase, '0);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    drop_d    = drop_q;
    win_mag_d = win_mag_q;
    win_ph_d  = win_ph_q;
    rec_d     = rec_q;
    eval_a    = 1'b0;
    eval_b    = 1'b0;
`ifdef PEAK_DETECT_MC_THRESH_EN
    thresh_d  = thresh_q;
`endif

    if (start) begin
      rec_d       = '{default: '0};
      win_mag_d[1] = '0;
      win_ph_d[1]  = '0;
      win_mag_d[0] = bus.sink_mag;
      win_ph_d[0]  = bus.sink_phase;
      cnt_d        = CWIDTH'(1);
`ifdef PEAK_DETECT_MC_THRESH_EN
      thresh_d     = bus.sink_thresh;
`endif
      if (bus.sink_eop) begin
        eval_b  = 1'b1;
        state_d = EMIT;
        drop_d  = 1'b0;
      end else begin
        state_d = SCAN;
      end
    end else if (state_q == SCAN && accept) begin
      eval_a       = 1'b1;
      win_mag_d[1] = win_mag_q[0];
      win_ph_d[1]  = win_ph_q[0];
      win_mag_d[0] = bus.sink_mag;
      win_ph_d[0]  = bus.sink_phase;
      cnt_d        = cnt_q + CWIDTH'(1);
      if (bus.sink_eop) begin
        eval_b  = (int'(cnt_q) < LIMIT);
        state_d = EMIT;
        drop_d  = 1'b0;
      end else if (int'(cnt_q) == LIMIT) begin
        // Frame continues past the last range: swallow the tail while emitting.
        state_d = EMIT;
        drop_d  = 1'b1;
      end
    end else if (state_q == EMIT) begin
      if (accept && bus.sink_eop) drop_d = 1'b0;
      if (bus.source_ready) begin
        if (idx_q == IWIDTH'(NPEAKS - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
          drop_d  = 1'b0;
          rec_d   = '{default: '0};
        end else begin
          idx_d = idx_q + IWIDTH'(1);
        end
      end
    end

    for (int i = 0; i < NPEAKS; i++) begin
      if (eval_a) rec_d[i] = offer(rec_d[i], cand_a, i);
      if (eval_b) rec_d[i] = offer(rec_d[i], cand_b, i);
    end
  end

  always_comb begin
    cur_rec          = rec_q[idx_q];
    bus.source_valid = 1'b0;
    bus.source_sop   = 1'b0;
    bus.source_eop   = 1'b0;
    bus.source_found = 1'b0;
    bus.source_bin   = '0;
    bus.source_mag   = '0;
    bus.source_phase = '0;
    if (state_q == EMIT) begin
      bus.source_valid = 1'b1;
      bus.source_sop   = (idx_q == '0);
      bus.source_eop   = (idx_q == IWIDTH'(NPEAKS - 1));
      bus.source_bin   = cur_rec.valid ? cur_rec.bin : BWIDTH'(PEAKSEP[idx_q]);
      bus.source_mag   = cur_rec.mag;
      bus.source_phase = cur_rec.phase;
`ifdef PEAK_DETECT_MC_THRESH_EN
      bus.source_found = cur_rec.valid && (cur_rec.mag[WIDTH +: WIDTH] >= thresh_q);
`else
      bus.source_found = cur_rec.valid;
`endif
    end
  end

  // NOTE: state updates use non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      drop_q  <= 1'b0;
      // NOTE: window and records are small flop arrays, not RAM, so they take the reset too.
      for (int i = 0; i < 2; i++) begin
        win_mag_q[i] <= '0;
        win_ph_q[i]  <= '0;
      end
      for (int i = 0; i < NPEAKS; i++) rec_q[i] <= '0;
`ifdef PEAK_DETECT_MC_THRESH_EN
      thresh_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      drop_q    <= drop_d;
      win_mag_q <= win_mag_d;
      win_ph_q  <= win_ph_d;
      rec_q     <= rec_d;
`ifdef PEAK_DETECT_MC_THRESH_EN
      thresh_q  <= thresh_d;
`endif
    end
  end
endmodule

// File: tb/tb_peak_detect_mc.sv
// Self-checking bench for peak_detect_mc: randomized frames scored against a per-range
// "strongest bin" reference model computed directly from the frame contents.
module tb_peak_detect_mc;
  localparam int WIDTH  = 16;
  localparam int NCH    = 2;
  localparam int REFCH  = 0;
  localparam int NPEAKS = 2;
  localparam int BWIDTH = 7;
  localparam int MAXB   = 128;
  localparam int SEP [0:NPEAKS] = '{4, 64, 128};

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   thresh_v;

  logic [15:0] fr_mag [NCH][MAXB];
  logic [15:0] fr_ph  [NCH][MAXB];

  logic [BWIDTH-1:0]  exp_bin   [NPEAKS];
  logic [3*WIDTH-1:0] exp_mag   [NPEAKS];
  logic [NCH*48-1:0]  exp_ph    [NPEAKS];
  logic               exp_found [NPEAKS];

  peak_detect_mc_if #(.WIDTH(WIDTH), .NCH(NCH), .BWIDTH(BWIDTH)) bus ();

  peak_detect_mc #(.WIDTH(WIDTH), .NCH(NCH), .REFCH(REFCH), .NPEAKS(NPEAKS)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  // Reference: per range, first bin with the largest REFCH magnitude above the running best
  // (starting at 0); neighbours outside the frame read as zero.
  task automatic model(input int len);
    for (int i = 0; i < NPEAKS; i++) begin
      int best;
      int bm;
      best = -1;
      bm   = 0;
      for (int k = SEP[i]; k < SEP[i+1] && k < len; k++) begin
        if (int'(fr_mag[REFCH][k]) > bm) begin
          bm   = int'(fr_mag[REFCH][k]);
          best = k;
        end
      end
      exp_found[i] = (best >= 0) && (bm >= thresh_v);
      exp_bin[i]   = BWIDTH'((best >= 0) ? best : SEP[i]);
      exp_mag[i]   = '0;
      exp_ph[i]    = '0;
      if (best >= 0) begin
        for (int j = 0; j < 3; j++) begin
          int b;
          b = best - 1 + j;
          if (b >= 0 && b < len) begin
            exp_mag[i][j*16 +: 16] = fr_mag[REFCH][b];
            for (int c = 0; c < NCH; c++) exp_ph[i][c*48 + j*16 +: 16] = fr_ph[c][b];
          end
        end
      end
    end
  endtask

  task automatic fill(input bit rand_ref);
    for (int n = 0; n < MAXB; n++) begin
      for (int c = 0; c < NCH; c++) begin
        fr_mag[c][n] = 16'($urandom);
        fr_ph[c][n]  = 16'($urandom);
      end
      fr_mag[REFCH][n] = rand_ref ? 16'($urandom_range(0, 1000)) : 16'd10;
    end
  endtask

  task automatic fill_basic();
    fill(1'b0);
    fr_mag[REFCH][20] = 16'd500;
    fr_mag[REFCH][90] = 16'd300;
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic drive_frame(input int len, input bit with_eop, input bit gaps);
    int n;
    int guard;
    bit acc;
    n     = 0;
    guard = 0;
    while (n < len && guard < 2000) begin
      bus.sink_valid = !(gaps && $urandom_range(0, 3) == 0);
      bus.sink_sop   = (n == 0);
      bus.sink_eop   = with_eop && (n == len - 1);
      for (int c = 0; c < NCH; c++) begin
        bus.sink_mag[c*16 +: 16]   = fr_mag[c][n];
        bus.sink_phase[c*16 +: 16] = fr_ph[c][n];
      end
      if (bus.sink_valid) begin
        n_checks++;
        if (bus.sink_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL frame sink_ready bin %0d: got %b want 1", n, bus.sink_ready);
        end
      end
      acc = bus.sink_valid && bus.sink_ready;
      @(posedge clk);
      #1;
      if (acc) n++;
      guard++;
    end
    bus.sink_valid = 1'b0;
    bus.sink_sop   = 1'b0;
    bus.sink_eop   = 1'b0;
    n_checks++;
    if (n != len) begin
      n_fail++;
      $display("FAIL frame beats_sent: got %0d want %0d", n, len);
    end
  endtask

  // mode 0: ready held high; 1: ready alternates starting low; 2: ready random.
  task automatic collect(input string tag, input int mode);
    int got;
    int cyc;
    bit stalled;
    logic [BWIDTH+3*WIDTH+NCH*48+3:0] held;
    logic [BWIDTH+3*WIDTH+NCH*48+3:0] now;
    got     = 0;
    cyc     = 0;
    stalled = 1'b0;
    held    = '0;
    n_checks++;
    if (bus.source_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s first_valid: got %b want 1", tag, bus.source_valid);
    end
    while (got < NPEAKS && cyc < 64) begin
      case (mode)
        0:       bus.source_ready = 1'b1;
        1:       bus.source_ready = (cyc % 2 == 1);
        default: bus.source_ready = 1'($urandom_range(0, 1));
      endcase
      now = {bus.source_valid, bus.source_sop, bus.source_eop, bus.source_found,
             bus.source_bin, bus.source_mag, bus.source_phase};
      if (stalled) begin
        n_checks++;
        if (now !== held) begin
          n_fail++;
          $display("FAIL %s hold rec %0d: got %h want %h", tag, got, now, held);
        end
      end
      if (bus.source_valid === 1'b1) begin
        n_checks++;
        if (bus.sink_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL %s sink_ready_in_emit: got %b want 0", tag, bus.sink_ready);
        end
        if (bus.source_ready) begin
          n_checks++;
          if (bus.source_sop !== (got == 0) || bus.source_eop !== (got == NPEAKS - 1)) begin
            n_fail++;
            $display("FAIL %s sop_eop rec %0d: got %b%b want %b%b", tag, got,
                     bus.source_sop, bus.source_eop, got == 0, got == NPEAKS - 1);
          end
          n_checks++;
          if (bus.source_bin !== exp_bin[got]) begin
            n_fail++;
            $display("FAIL %s bin rec %0d: got %0d want %0d", tag, got, bus.source_bin, exp_bin[got]);
          end
          n_checks++;
          if (bus.source_mag !== exp_mag[got]) begin
            n_fail++;
            $display("FAIL %s mag rec %0d: got %h want %h", tag, got, bus.source_mag, exp_mag[got]);
          end
          n_checks++;
          if (bus.source_phase !== exp_ph[got]) begin
            n_fail++;
            $display("FAIL %s phase rec %0d: got %h want %h", tag, got, bus.source_phase, exp_ph[got]);
          end
          n_checks++;
          if (bus.source_found !== exp_found[got]) begin
            n_fail++;
            $display("FAIL %s found rec %0d: got %b want %b", tag, got, bus.source_found, exp_found[got]);
          end
          got++;
        end
      end
      stalled = (bus.source_valid === 1'b1) && !bus.source_ready;
      held    = now;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.source_ready = 1'b0;
    n_checks++;
    if (got != NPEAKS) begin
      n_fail++;
      $display("FAIL %s record_count: got %0d want %0d", tag, got, NPEAKS);
    end
    if (mode == 0) begin
      n_checks++;
      if (cyc != NPEAKS) begin
        n_fail++;
        $display("FAIL %s emit_cycles: got %0d want %0d", tag, cyc, NPEAKS);
      end
    end
    n_checks++;
    if (bus.source_valid !== 1'b0 || bus.sink_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s back_to_idle: got valid=%b ready=%b want valid=0 ready=1", tag,
               bus.source_valid, bus.sink_ready);
    end
  endtask

  task automatic check_quiet(input string tag);
    n_checks++;
    if ({bus.source_valid, bus.source_sop, bus.source_eop, bus.source_found} !== 4'b0 ||
        bus.source_bin !== '0 || bus.source_mag !== '0 || bus.source_phase !== '0 ||
        bus.sink_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s outputs: got v%b s%b e%b f%b bin=%0d mag=%h ph=%h rdy=%b want all 0, rdy=1",
               tag, bus.source_valid, bus.source_sop, bus.source_eop, bus.source_found,
               bus.source_bin, bus.source_mag, bus.source_phase, bus.sink_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_quiet("after_reset");
  endtask

  task automatic test_basic();
    fill_basic();
    drive_frame(128, 1'b1, 1'b0);
    model(128);
    collect("basic", 0);
  endtask

  task automatic test_tie();
    fill(1'b1);
    for (int n = SEP[0]; n < SEP[1]; n++) fr_mag[REFCH][n] = 16'($urandom_range(0, 200));
    fr_mag[REFCH][30] = 16'd900;
    fr_mag[REFCH][40] = 16'd900;
    drive_frame(128, 1'b1, 1'b1);
    model(128);
    collect("tie", 0);
  endtask

  task automatic test_stall();
    fill_basic();
    drive_frame(128, 1'b1, 1'b0);
    model(128);
    collect("stall", 1);
  endtask

  task automatic test_early_eop();
    fill(1'b0);
    drive_frame(51, 1'b1, 1'b0);
    model(51);
    collect("early_eop", 0);
  endtask

  task automatic test_idle_ignore();
    fill(1'b1);
    for (int n = 0; n < 3; n++) begin
      bus.sink_valid = 1'b1;
      bus.sink_sop   = 1'b0;
      bus.sink_eop   = (n == 2);
      bus.sink_mag   = '1;
      @(posedge clk);
      #1;
    end
    bus.sink_valid = 1'b0;
    bus.sink_eop   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("idle_ignore");
  endtask

  task automatic test_sop_restart();
    fill(1'b1);
    fr_mag[REFCH][10] = 16'd5000;
    drive_frame(40, 1'b0, 1'b0);
    fill(1'b1);
    drive_frame(128, 1'b1, 1'b0);
    model(128);
    collect("sop_restart", 2);
  endtask

  task automatic test_reset_mid();
    fill(1'b1);
    fr_mag[REFCH][10] = 16'd5000;
    drive_frame(71, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check_quiet("reset_mid_frame");
    @(posedge clk);
    #1;
    reset = 1'b1;
    fill(1'b1);
    drive_frame(128, 1'b1, 1'b0);
    n_checks++;
    if (bus.source_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_emit pre_valid: got %b want 1", bus.source_valid);
    end
    reset = 1'b0;
    #1;
    check_quiet("reset_mid_emit");
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset_no_output");
    fill(1'b1);
    drive_frame(128, 1'b1, 1'b1);
    model(128);
    collect("reset_fresh", 0);
  endtask

  task automatic test_random();
    int lens [8] = '{1, 2, 5, 64, 65, 128, 0, 0};
    lens[6] = $urandom_range(3, 127);
    lens[7] = $urandom_range(3, 127);
    for (int f = 0; f < 8; f++) begin
      fill(1'b1);
      drive_frame(lens[f], 1'b1, 1'b1);
      model(lens[f]);
      collect($sformatf("random_len%0d", lens[f]), 2);
    end
  endtask

`ifdef PEAK_DETECT_MC_THRESH_EN
  task automatic test_thresh();
    fill_basic();
    thresh_v        = 400;
    bus.sink_thresh = 16'd400;
    drive_frame(128, 1'b1, 1'b0);
    bus.sink_thresh = '0;
    model(128);
    collect("thresh", 0);
    thresh_v = 0;
  endtask
`endif

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    thresh_v         = 0;
    reset            = 1'b0;
    bus.sink_valid   = 1'b0;
    bus.sink_sop     = 1'b0;
    bus.sink_eop     = 1'b0;
    bus.sink_mag     = '0;
    bus.sink_phase   = '0;
    bus.source_ready = 1'b0;
`ifdef PEAK_DETECT_MC_THRESH_EN
    bus.sink_thresh  = '0;
`endif
    test_reset();
    test_basic();
    test_tie();
    test_stall();
    test_early_eop();
    test_idle_ignore();
    test_sop_restart();
    test_reset_mid();
    test_random();
`ifdef PEAK_DETECT_MC_THRESH_EN
    test_thresh();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
